// File: rtl/round_tracker_mp_if.sv
// round_tracker_mp_if: strobes from game control in, per-player score/turn view out
interface round_tracker_mp_if #(
  parameter int ROUND_W = 4,
  parameter int PLAYERS = 2,
  parameter int MISS_W  = 2
);
  localparam int PL_W = PLAYERS > 1 ? $clog2(PLAYERS) : 1;
  logic               start;
  logic               e;
  logic               miss;
  logic [ROUND_W-1:0] data;
  logic [ROUND_W-1:0] round;
  logic [MISS_W-1:0]  misses;
  logic [PL_W-1:0]    player;
  logic               busy;
  logic               tc;
  logic               lose;
  logic [PL_W-1:0]    winner;
  modport master (output start, e, miss, data,
                  input round, misses, player, busy, tc, lose, winner);
  modport slave  (input start, e, miss, data,
                  output round, misses, player, busy, tc, lose, winner);
endinterface

// File: rtl/round_tracker_mp.sv
// round_tracker_mp: per-player round/miss counters, turn rotation, win/lose detection
module round_tracker_mp #(
  parameter int ROUND_W    = 4,
  parameter int PLAYERS    = 2,
  parameter int MAX_MISSES = 3,
  parameter int MISS_W     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  round_tracker_mp_if.slave   bus
);
  localparam int PL_W = PLAYERS > 1 ? $clog2(PLAYERS) : 1;
  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;
  state_t             state_q, state_d;
  logic [ROUND_W-1:0] round_q [PLAYERS];
  logic [ROUND_W-1:0] round_d [PLAYERS];
  logic [MISS_W-1:0]  miss_q [PLAYERS];
  logic [MISS_W-1:0]  miss_d [PLAYERS];
  logic [PLAYERS-1:0] elim_q, elim_d;
  logic [PL_W-1:0]    active_q, active_d, winner_q, winner_d;
  logic [ROUND_W-1:0] target_q, target_d, round_inc;
  logic [MISS_W-1:0]  miss_inc;
  // First non-eliminated player after a, wrapping; a itself if nobody else is left
  function automatic logic [PL_W-1:0] next_player(input logic [PL_W-1:0] a,
                                                  input logic [PLAYERS-1:0] el);
    logic [PL_W-1:0] n;
    logic [PL_W-1:0] p;
    logic            f;
    int              idx;
    n = a;
    f = 1'b0;
    for (int k = 1; k < PLAYERS; k++) begin
      idx = int'(a) + k;
      if (idx >= PLAYERS) idx = idx - PLAYERS;
      p = PL_W'(idx);
      if (!f && !el[p]) begin
        n = p;
        f = 1'b1;
      end
    end
    return n;
  endfunction
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    miss_d    = miss_q;
    elim_d    = elim_q;
    active_d  = active_q;
    winner_d  = winner_q;
    target_d  = target_q;
    round_inc = round_q[active_q] + ROUND_W'(1);
    miss_inc  = miss_q[active_q] + MISS_W'(1);
    if (bus.start && bus.data != '0) begin
      target_d = bus.data;
      round_d  = '{default: '0};
      miss_d   = '{default: '0};
      elim_d   = '0;
      active_d = '0;
      state_d  = PLAY;
    end else if (state_q == PLAY && bus.miss) begin
      miss_d[active_q] = miss_inc;
      if (miss_inc == MISS_W'(MAX_MISSES)) elim_d[active_q] = 1'b1;
      active_d = next_player(active_q, elim_d);
      if (&elim_d) state_d = LOSE;
    end else if (state_q == PLAY && bus.e) begin
      round_d[active_q] = round_inc;
      if (round_inc == target_q) begin
        state_d  = WIN;
        winner_d = active_q;
      end else begin
        active_d = next_player(active_q, elim_q);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      round_q  <= '{default: '0};
      miss_q   <= '{default: '0};
      elim_q   <= '0;
      active_q <= '0;
      winner_q <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      miss_q   <= miss_d;
      elim_q   <= elim_d;
      active_q <= active_d;
      winner_q <= winner_d;
      target_q <= target_d;
    end
  end
  assign bus.round  = round_q[active_q];
  assign bus.misses = miss_q[active_q];
  assign bus.player = active_q;
  assign bus.busy   = state_q == PLAY;
  assign bus.tc     = state_q == WIN;
  assign bus.lose   = state_q == LOSE;
  assign bus.winner = winner_q;
endmodule

// File: tb/tb_round_tracker_mp.sv
// tb_round_tracker_mp: three trackers (2, 3, 1 players) share one stimulus stream
module tb_round_tracker_mp;
  localparam int MAXM = 3;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, e = 1'b0, miss = 1'b0;
  logic [3:0] data = '0;
  int         total = 0, bad = 0;
  always #5 clk = ~clk;
  round_tracker_mp_if #(.PLAYERS(2)) b0 ();
  round_tracker_mp_if #(.PLAYERS(3)) b1 ();
  round_tracker_mp_if #(.PLAYERS(1)) b2 ();
  round_tracker_mp #(.PLAYERS(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  round_tracker_mp #(.PLAYERS(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  round_tracker_mp #(.PLAYERS(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  assign b0.start = start; assign b0.e = e; assign b0.miss = miss; assign b0.data = data;
  assign b1.start = start; assign b1.e = e; assign b1.miss = miss; assign b1.data = data;
  assign b2.start = start; assign b2.e = e; assign b2.miss = miss; assign b2.data = data;
  logic [3:0] o_round [3];
  logic [1:0] o_miss [3];
  logic [2:0] o_player [3], o_winner [3];
  logic       o_busy [3], o_tc [3], o_lose [3];
  assign o_round[0] = b0.round; assign o_miss[0] = b0.misses; assign o_player[0] = 3'(b0.player);
  assign o_busy[0] = b0.busy; assign o_tc[0] = b0.tc; assign o_lose[0] = b0.lose; assign o_winner[0] = 3'(b0.winner);
  assign o_round[1] = b1.round; assign o_miss[1] = b1.misses; assign o_player[1] = 3'(b1.player);
  assign o_busy[1] = b1.busy; assign o_tc[1] = b1.tc; assign o_lose[1] = b1.lose; assign o_winner[1] = 3'(b1.winner);
  assign o_round[2] = b2.round; assign o_miss[2] = b2.misses; assign o_player[2] = 3'(b2.player);
  assign o_busy[2] = b2.busy; assign o_tc[2] = b2.tc; assign o_lose[2] = b2.lose; assign o_winner[2] = 3'(b2.winner);
  // Reference game state, one row per tracker
  int np [3] = '{2, 3, 1};
  int rnd [3][8], mis [3][8], act [3], tgt [3], win [3];
  bit el [3][8], play [3], won [3], lost [3];
  function automatic int adv(int d, int a);
    for (int k = 1; k < np[d]; k++)
      if (!el[d][(a + k) % np[d]]) return (a + k) % np[d];
    return a;
  endfunction
  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 8; p++) begin
        rnd[d][p] = 0; mis[d][p] = 0; el[d][p] = 1'b0;
      end
      act[d] = 0; tgt[d] = 0; win[d] = 0;
      play[d] = 1'b0; won[d] = 1'b0; lost[d] = 1'b0;
    end
  endtask
  task automatic model_step(bit s, bit ev, bit m, int dv);
    for (int d = 0; d < 3; d++) begin
      int a = act[d];
      int alive = 0;
      if (s && dv != 0) begin
        for (int p = 0; p < 8; p++) begin
          rnd[d][p] = 0; mis[d][p] = 0; el[d][p] = 1'b0;
        end
        tgt[d] = dv; act[d] = 0;
        play[d] = 1'b1; won[d] = 1'b0; lost[d] = 1'b0;
      end else if (play[d] && m) begin
        mis[d][a]++;
        if (mis[d][a] == MAXM) el[d][a] = 1'b1;
        act[d] = adv(d, a);
        for (int p = 0; p < np[d]; p++) if (!el[d][p]) alive++;
        if (alive == 0) begin
          play[d] = 1'b0; lost[d] = 1'b1;
        end
      end else if (play[d] && ev) begin
        rnd[d][a]++;
        if (rnd[d][a] == tgt[d]) begin
          play[d] = 1'b0; won[d] = 1'b1; win[d] = a;
        end else begin
          act[d] = adv(d, a);
        end
      end
    end
  endtask
  task automatic chk(input string tag, input int d, input logic [31:0] got, input int exp);
    total++;
    assert (got === 32'(exp)) else begin
      bad++;
      $error("FAIL %s dut%0d got=%0d exp=%0d", tag, d, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, " round"}, d, 32'(o_round[d]), rnd[d][act[d]]);
      chk({tag, " misses"}, d, 32'(o_miss[d]), mis[d][act[d]]);
      chk({tag, " player"}, d, 32'(o_player[d]), act[d]);
      chk({tag, " busy"}, d, 32'(o_busy[d]), int'(play[d]));
      chk({tag, " tc"}, d, 32'(o_tc[d]), int'(won[d]));
      chk({tag, " lose"}, d, 32'(o_lose[d]), int'(lost[d]));
      if (won[d]) chk({tag, " winner"}, d, 32'(o_winner[d]), win[d]);
    end
  endtask
  task automatic tick(input bit s, input bit ev, input bit m, input int dv, input string tag);
    start = s; e = ev; miss = m; data = 4'(dv);
    @(posedge clk);
    #1;
    start = 1'b0; e = 1'b0; miss = 1'b0;
    model_step(s, ev, m, dv);
    check_all(tag);
  endtask
  // Reset dropped between edges must take effect before the next clock
  task automatic arst();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_all("reset held");
  endtask
  initial begin
    #2;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1, 0, 0, 3, "t1 start");
    repeat (5) tick(0, 1, 0, 0, "t1 E");
    repeat (2) tick(0, 1, 0, 0, "t1 E after win");
    tick(1, 0, 0, 5, "t2 start");
    repeat (3) begin
      tick(0, 1, 0, 0, "t2 E");
      tick(0, 0, 1, 0, "t2 miss");
    end
    repeat (3) tick(0, 1, 0, 0, "t2 E solo");
    tick(1, 0, 0, 15, "t3 start");
    repeat (10) tick(0, 0, 1, 0, "t3 miss");
    repeat (2) tick(0, 1, 0, 0, "t3 E ignored");
    tick(0, 0, 1, 0, "t3 miss ignored");
    tick(1, 0, 0, 7, "t3 restart");
    tick(0, 1, 1, 0, "t4 E+miss");
    tick(1, 1, 0, 5, "t4 start+E");
    tick(0, 1, 1, 0, "t4 E+miss 2");
    tick(1, 0, 0, 0, "t4 start d0");
    tick(0, 1, 0, 0, "t4 E");
    repeat (3) tick(0, 1, 0, 0, "t5 E");
    arst();
    tick(0, 1, 0, 0, "t5 idle E");
    tick(1, 0, 0, 4, "t5 start");
    tick(1, 0, 0, 15, "t6 start");
    repeat (32) tick(0, 1, 0, 0, "t6 E");
    for (int i = 0; i < 600; i++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 4)
        tick(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), "rnd start");
      else if (r == 4)
        arst();
      else
        tick(0, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25, int'($urandom_range(0, 15)), "rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
